sm2201_isa_cycle_controller: RTL
================================

Name: sm2201_isa_cycle_controller

Overview:
- Front-end stage between the ISA slot and the SM2201 CAMAC register side.
- Latches and decodes the ISA I/O address and synchronises IOR/IOW, then pairs 8-bit ISA byte accesses into 16-bit register reads/writes.
- Holds the bus with CHRDY until the CAMAC side acknowledges, or until a timeout expires.
- Drives the register strobe interface consumed by the CAMAC cycle logic.

Parameters:
- BASE_ADDR, 10'h100, base of the decoded I/O window.
- WIN_BITS, 6, window size 2^WIN_BITS bytes (0x100-0x13F).
- TIMEOUT_CYCLES, 64, isa_clk cycles to wait for reg_ack before abandoning the access.

Ports:
- isa_clk  in  1  ISA bus clock; sole clock.
- isa_reset  in  1  asynchronous, active-low reset.
- isa_addr  in  10  ISA SA[9:0].
- isa_ale  in  1  address latch enable; high = address transparent.
- isa_aen  in  1  DMA cycle flag; 1 = ignore the cycle.
- isa_ior  in  1  I/O read strobe, active low.
- isa_iow  in  1  I/O write strobe, active low.
- isa_data_in  in  8  SD[7:0] during writes.
- isa_data_out  out  8  SD[7:0] during reads.
- isa_data_oe  out  1  SD driver enable.
- isa_chrdy  out  1  0 = insert wait states.
- reg_addr  out  WIN_BITS-1  16-bit word address within the window.
- reg_wr_data  out  16  paired write word.
- reg_wr_stb  out  1  one-cycle write request.
- reg_rd_stb  out  1  one-cycle read request.
- reg_rd_data  in  16  read word; valid when reg_ack=1.
- reg_ack  in  1  one-cycle completion from the CAMAC side.
- timeout_flag  out  1  sticky; set on timeout, cleared by reset or by a write to window offset 0x3F.

Behaviour:
- Reset (isa_reset=0, async): isa_chrdy=1, isa_data_oe=0, isa_data_out=0, reg_wr_stb=0, reg_rd_stb=0, reg_addr=0, reg_wr_data=0, timeout_flag=0. Low/high byte holding registers cleared. FSM goes to IDLE.
- Reset mid-access releases CHRDY immediately. No strobe is emitted for the aborted access.
- Address latch: loads isa_addr on every clock while isa_ale=1; holds its value while isa_ale=0.
- Strobes: isa_ior and isa_iow each pass through a 2-flop synchroniser. A falling edge is detected on the synchronised value. Raw assert at edge n is detected at edge n+2.
- Hit condition: latched_addr[9:WIN_BITS]==BASE_ADDR[9:WIN_BITS] and isa_aen=0 at detection. Misses never touch any output.
- Both strobes detected low in the same cycle: ignored, FSM stays IDLE.
- FSM states: IDLE, DECODE, WAIT_ACK, DONE, RELEASE.
- IDLE -> DECODE on a hit.
- DECODE, even write: store isa_data_in to the low holding register; go to DONE with no CHRDY wait.
- DECODE, odd write: reg_wr_data={isa_data_in, low_hold}, reg_addr=latched_addr[WIN_BITS-1:1]; pulse reg_wr_stb for 1 cycle; drive isa_chrdy=0; go to WAIT_ACK.
- DECODE, even read: pulse reg_rd_stb, set reg_addr, drive isa_chrdy=0, go to WAIT_ACK.
- DECODE, odd read: isa_data_out=high holding register; go to DONE. No downstream cycle is issued.
- WAIT_ACK, reg_ack=1 on a read: capture reg_rd_data; isa_data_out=reg_rd_data[7:0]; high holding register = reg_rd_data[15:8].
- WAIT_ACK, reg_ack=1 (read or write): isa_chrdy=1 on the next edge; go to DONE.
- WAIT_ACK timeout: an internal counter reaches TIMEOUT_CYCLES-1. Then isa_chrdy=1, timeout_flag=1, read data = 8'hFF (high holding = 8'hFF), go to DONE.
- reg_ack arriving in the same cycle as the timeout terminal count wins; timeout_flag is not set.
- isa_data_oe=1 from DECODE (odd read) or ack/timeout (even read) until the synchronised IOR deasserts.
- DONE -> RELEASE when the synchronised strobe returns high. RELEASE -> IDLE after 1 cycle; isa_data_oe=0 in RELEASE.
- A stray reg_ack outside WAIT_ACK is ignored.
- A write to offset 0x3F also clears timeout_flag. That byte still goes through normal odd-write pairing.
- Odd write without a prior even write uses the current low_hold value (0 after reset).
- Exactly one of reg_wr_stb/reg_rd_stb pulses per downstream access. Never both.

Test Plan:
- Reset, then write 0x34 to 0x100 and 0x12 to 0x101, ack 3 cycles after the strobe -> one reg_wr_stb, reg_wr_data=16'h1234, reg_addr=0; CHRDY low for exactly the wait window; no strobe on the 0x100 byte.
- Read 0x102 with reg_rd_data=16'hABCD, ack after 5 cycles -> reg_rd_stb once, reg_addr=1, SD=0xCD; then read 0x103 -> SD=0xAB with no reg_rd_stb.
- Read 0x104 with no ack -> CHRDY released after 64 cycles, SD=0xFF, timeout_flag=1; then write to 0x13F -> timeout_flag=0.
- Access 0x140 and 0x0FF, and 0x100 with isa_aen=1 -> no strobes, CHRDY stays 1, isa_data_oe stays 0.
- Assert isa_reset=0 during WAIT_ACK -> CHRDY=1 and all outputs at reset values asynchronously; a later ack produces no effect.
- Sweep 0x100-0x13E with alternating read/write pairs, ISA strobe held ~116 clocks per access -> every pair yields a single correct 16-bit transaction and the FSM returns to IDLE between accesses.

Source files
------------

// File: rtl/sm2201_isa_cycle_controller.sv
// SM2201 ISA front end: address decode, strobe sync, byte pairing and
// CHRDY wait-state control toward the CAMAC register strobe interface.
module sm2201_isa_cycle_controller #(
    parameter logic [9:0] BASE_ADDR      = 10'h100,
    parameter int         WIN_BITS       = 6,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                isa_clk,
    input  logic                isa_reset,
    input  logic [9:0]          isa_addr,
    input  logic                isa_ale,
    input  logic                isa_aen,
    input  logic                isa_ior,
    input  logic                isa_iow,
    input  logic [7:0]          isa_data_in,
    output logic [7:0]          isa_data_out,
    output logic                isa_data_oe,
    output logic                isa_chrdy,
    output logic [WIN_BITS-2:0] reg_addr,
    output logic [15:0]         reg_wr_data,
    output logic                reg_wr_stb,
    output logic                reg_rd_stb,
    input  logic [15:0]         reg_rd_data,
    input  logic                reg_ack,
    output logic                timeout_flag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIN_BITS-1:0] OFF_CLR = '1;

    logic [9:0]          r_addr;
    logic                r_ior_s1, r_ior_s2, r_ior_q;
    logic                r_iow_s1, r_iow_s2, r_iow_q;
    logic [2:0]          r_state;
    logic                r_is_rd;
    logic [WIN_BITS-1:0] r_off;
    logic [7:0]          r_lo_hold;
    logic [7:0]          r_hi_hold;
    logic [CNT_W-1:0]    r_cnt;

    logic w_hit;
    logic w_rd_go;
    logic w_wr_go;
    logic w_strobe_hi;

    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_addr <= '0;
        end else if (isa_ale) begin
            r_addr <= isa_addr;
        end
    end

    // Strobes idle high; sync chain resets to the idle level.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_ior_s1 <= 1'b1;
            r_ior_s2 <= 1'b1;
            r_ior_q  <= 1'b1;
            r_iow_s1 <= 1'b1;
            r_iow_s2 <= 1'b1;
            r_iow_q  <= 1'b1;
        end else begin
            r_ior_s1 <= isa_ior;
            r_ior_s2 <= r_ior_s1;
            r_ior_q  <= r_ior_s2;
            r_iow_s1 <= isa_iow;
            r_iow_s2 <= r_iow_s1;
            r_iow_q  <= r_iow_s2;
        end
    end

    assign w_hit = (r_addr[9:WIN_BITS] == BASE_ADDR[9:WIN_BITS]) && !isa_aen;
    // A fall on one strobe only counts while the other is still high.
    assign w_rd_go = r_ior_q & ~r_ior_s2 & r_iow_s2;
    assign w_wr_go = r_iow_q & ~r_iow_s2 & r_ior_s2;
    assign w_strobe_hi = r_is_rd ? r_ior_s2 : r_iow_s2;

    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_state      <= S_IDLE;
            r_is_rd      <= 1'b0;
            r_off        <= '0;
            r_lo_hold    <= '0;
            r_hi_hold    <= '0;
            r_cnt        <= '0;
            isa_data_out <= '0;
            isa_data_oe  <= 1'b0;
            isa_chrdy    <= 1'b1;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
            reg_wr_stb   <= 1'b0;
            reg_rd_stb   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit && (w_rd_go || w_wr_go)) begin
                        r_is_rd <= w_rd_go;
                        r_off   <= r_addr[WIN_BITS-1:0];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_cnt <= '0;
                    if (r_is_rd) begin
                        if (r_off[0]) begin
                            isa_data_out <= r_hi_hold;
                            isa_data_oe  <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            reg_rd_stb <= 1'b1;
                            reg_addr   <= r_off[WIN_BITS-1:1];
                            isa_chrdy  <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end else if (r_off[0]) begin
                        reg_wr_data <= {isa_data_in, r_lo_hold};
                        reg_addr    <= r_off[WIN_BITS-1:1];
                        reg_wr_stb  <= 1'b1;
                        isa_chrdy   <= 1'b0;
                        r_state     <= S_WAIT;
                        if (r_off == OFF_CLR) begin
                            timeout_flag <= 1'b0;
                        end
                    end else begin
                        r_lo_hold <= isa_data_in;
                        r_state   <= S_DONE;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (reg_ack) begin
                        if (r_is_rd) begin
                            isa_data_out <= reg_rd_data[7:0];
                            r_hi_hold    <= reg_rd_data[15:8];
                            isa_data_oe  <= 1'b1;
                        end
                        isa_chrdy <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        if (r_is_rd) begin
                            isa_data_out <= 8'hFF;
                            r_hi_hold    <= 8'hFF;
                            isa_data_oe  <= 1'b1;
                        end
                        isa_chrdy    <= 1'b1;
                        timeout_flag <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_strobe_hi) begin
                        isa_data_oe <= 1'b0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    isa_data_oe <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
